// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch sequencer: PC, next-PC select, IN stall, HALT freeze
module pc_sequencer #(
   parameter int                  PC_WIDTH  = 10,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                  CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr,
   input  logic [31:0]          reg_data,
   input  logic                 jump,
   input  logic                 jumpreg,
   input  logic                 branch,
   input  logic                 branch_cond,
   input  logic                 halt,
   input  logic                 in,
   input  logic                 in_valid,
   input  logic                 resume,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus1,
   output logic [5:0]           opcode,
   output logic                 exec_en,
   output logic                 halted,
   output logic                 waiting_in,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      WAIT_IN = 2'b01,
      HALTED  = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t              state;
   logic [31:0]         br_offset;
   logic [PC_WIDTH-1:0] next_pc;
   logic                unused_bits;

   assign opcode     = instr[31:26];
   assign pc_plus1   = pc + PC_WIDTH'(1);
   assign br_offset  = {{16{instr[15]}}, instr[15:0]};
   assign halted     = (state == HALTED);
   assign waiting_in = (state == WAIT_IN);

   // Only the low PC_WIDTH bits of the jump sources feed the PC.
   assign unused_bits = ^{instr, reg_data};

   always_comb begin
      next_pc = pc_plus1;
      if (jumpreg)
         next_pc = reg_data[PC_WIDTH-1:0];
      else if (jump)
         next_pc = instr[PC_WIDTH-1:0];
      else if (branch && branch_cond)
         next_pc = pc_plus1 + br_offset[PC_WIDTH-1:0];
   end

   always_comb begin
      exec_en = 1'b0;
      if (rst_n) begin
         case (state)
            RUN:     exec_en = !halt && !(in && !in_valid);
            WAIT_IN: exec_en = in_valid;
            default: exec_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         state       <= RUN;
         instr_count <= '0;
      end else begin
         if (exec_en)
            instr_count <= instr_count + CNT_WIDTH'(1);
         case (state)
            RUN: begin
               if (halt)
                  state <= HALTED;
               else if (in && !in_valid)
                  state <= WAIT_IN;
               else
                  pc <= next_pc;
            end
            WAIT_IN: begin
               if (in_valid) begin
                  pc    <= pc_plus1;
                  state <= RUN;
               end
            end
            HALTED: begin
               if (resume) begin
                  pc    <= pc_plus1;
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr, reg_data;
   logic        jump, jumpreg, branch, branch_cond, halt, in, in_valid, resume;
   logic [9:0]  pc, pc_plus1, pc_s, pc_plus1_s;
   logic [5:0]  opcode, opcode_s;
   logic        exec_en, halted, waiting_in, exec_en_s, halted_s, waiting_in_s;
   logic [15:0] instr_count;
   logic [3:0]  instr_count_s;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_cnt = '0;

   localparam logic [31:0] ADDI = 32'h2000_0001;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .reg_data(reg_data),
      .jump(jump), .jumpreg(jumpreg), .branch(branch), .branch_cond(branch_cond),
      .halt(halt), .in(in), .in_valid(in_valid), .resume(resume),
      .pc(pc), .pc_plus1(pc_plus1), .opcode(opcode), .exec_en(exec_en),
      .halted(halted), .waiting_in(waiting_in), .instr_count(instr_count)
   );

   // Narrow counter copy so the wrap point is reachable in a few cycles.
   pc_sequencer #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .instr(instr), .reg_data(reg_data),
      .jump(jump), .jumpreg(jumpreg), .branch(branch), .branch_cond(branch_cond),
      .halt(halt), .in(in), .in_valid(in_valid), .resume(resume),
      .pc(pc_s), .pc_plus1(pc_plus1_s), .opcode(opcode_s), .exec_en(exec_en_s),
      .halted(halted_s), .waiting_in(waiting_in_s), .instr_count(instr_count_s)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      instr = ADDI; reg_data = '0;
      jump = 0; jumpreg = 0; branch = 0; branch_cond = 0;
      halt = 0; in = 0; in_valid = 0; resume = 0;
   endtask

   task automatic goto_pc(input logic [9:0] tgt);
      idle();
      instr = 32'h0800_0000 | {22'd0, tgt};
      jump = 1;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      idle();
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #1;
      n_vec++; if (exec_en !== 1'b0) begin n_err++; $display("FAIL reset_exec_en got %b exp 0", exec_en); end
      tick();
      n_vec++; if (pc !== 10'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", pc); end
      n_vec++; if (instr_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", instr_count); end
      n_vec++; if ({halted, waiting_in} !== 2'b00) begin n_err++; $display("FAIL reset_state got %b exp 00", {halted, waiting_in}); end
      rst_n = 1;
      exp_cnt = 0;
      #1;
   endtask

   task automatic test_sequential();
      idle();
      #1;
      n_vec++; if (opcode !== 6'h08) begin n_err++; $display("FAIL opcode got %h exp 08", opcode); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (pc !== 10'(i)) begin n_err++; $display("FAIL seq_pc[%0d] got %0d exp %0d", i, pc, i); end
         n_vec++; if (pc_plus1 !== 10'(i + 1)) begin n_err++; $display("FAIL seq_pc_plus1[%0d] got %0d exp %0d", i, pc_plus1, i + 1); end
         n_vec++; if (exec_en !== 1'b1) begin n_err++; $display("FAIL seq_exec_en[%0d] got %b exp 1", i, exec_en); end
         n_vec++; if (instr_count !== 16'(i)) begin n_err++; $display("FAIL seq_cnt[%0d] got %0d exp %0d", i, instr_count, i); end
         tick();
         exp_cnt = exp_cnt + 16'd1;
      end
   endtask

   task automatic test_branch();
      goto_pc(10'd5);
      branch = 1; branch_cond = 1; instr = 32'h1000_FFFD;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd3) begin n_err++; $display("FAIL branch_taken got %0d exp 3", pc); end
      goto_pc(10'd5);
      branch = 1; branch_cond = 0; instr = 32'h1000_FFFD;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd6) begin n_err++; $display("FAIL branch_not_taken got %0d exp 6", pc); end
      n_vec++; if (instr_count !== exp_cnt) begin n_err++; $display("FAIL branch_cnt got %0d exp %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_jump_priority();
      goto_pc(10'd7);
      jump = 1; jumpreg = 1; instr = 32'h0800_0028; reg_data = 32'd100;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd100) begin n_err++; $display("FAIL jr_priority got %0d exp 100", pc); end
      jumpreg = 0; branch = 1; branch_cond = 1;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd40) begin n_err++; $display("FAIL jump_over_branch got %0d exp 40", pc); end
      idle();
   endtask

   task automatic test_wait_in();
      goto_pc(10'd9);
      in = 1; in_valid = 0;
      #1;
      n_vec++; if (exec_en !== 1'b0) begin n_err++; $display("FAIL in_run_exec_en got %b exp 0", exec_en); end
      tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if ({waiting_in, exec_en} !== 2'b10) begin n_err++; $display("FAIL wait[%0d] waiting/exec got %b exp 10", i, {waiting_in, exec_en}); end
         n_vec++; if (pc !== 10'd9) begin n_err++; $display("FAIL wait_pc[%0d] got %0d exp 9", i, pc); end
         tick();
      end
      in_valid = 1;
      #1;
      n_vec++; if ({waiting_in, exec_en} !== 2'b11) begin n_err++; $display("FAIL in_valid waiting/exec got %b exp 11", {waiting_in, exec_en}); end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      in = 0; in_valid = 0;
      #1;
      n_vec++; if (pc !== 10'd10 || waiting_in !== 1'b0) begin n_err++; $display("FAIL in_done pc/wait got %0d/%b exp 10/0", pc, waiting_in); end
      n_vec++; if (instr_count !== exp_cnt) begin n_err++; $display("FAIL in_cnt got %0d exp %0d", instr_count, exp_cnt); end
      in = 1; in_valid = 1;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd11 || waiting_in !== 1'b0) begin n_err++; $display("FAIL in_immediate pc/wait got %0d/%b exp 11/0", pc, waiting_in); end
      in_valid = 0;
      tick();
      n_vec++; if (waiting_in !== 1'b1) begin n_err++; $display("FAIL rewait got %b exp 1", waiting_in); end
      rst_n = 0;
      tick();
      exp_cnt = 0;
      n_vec++; if (pc !== 10'd0 || waiting_in !== 1'b0 || instr_count !== 16'd0) begin n_err++; $display("FAIL wait_reset pc/wait/cnt got %0d/%b/%0d exp 0/0/0", pc, waiting_in, instr_count); end
      rst_n = 1;
      idle();
   endtask

   task automatic test_halt();
      goto_pc(10'd12);
      halt = 1; jump = 1; instr = 32'h0800_0028;
      #1;
      n_vec++; if (exec_en !== 1'b0) begin n_err++; $display("FAIL halt_exec_en got %b exp 0", exec_en); end
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         n_vec++; if ({halted, exec_en} !== 2'b10 || pc !== 10'd12) begin n_err++; $display("FAIL halted[%0d] halted/exec/pc got %b/%0d exp 10/12", i, {halted, exec_en}, pc); end
         tick();
      end
      n_vec++; if (instr_count !== exp_cnt) begin n_err++; $display("FAIL halt_cnt got %0d exp %0d", instr_count, exp_cnt); end
      resume = 1;
      tick();
      resume = 0;
      n_vec++; if (halted !== 1'b0 || pc !== 10'd13) begin n_err++; $display("FAIL resume halted/pc got %b/%0d exp 0/13", halted, pc); end
      n_vec++; if (instr_count !== exp_cnt) begin n_err++; $display("FAIL resume_cnt got %0d exp %0d", instr_count, exp_cnt); end
      halt = 1;
      tick();
      halt = 0; rst_n = 0;
      #1;
      n_vec++; if (exec_en !== 1'b0) begin n_err++; $display("FAIL rst_exec_en got %b exp 0", exec_en); end
      tick();
      exp_cnt = 0;
      n_vec++; if (halted !== 1'b0 || pc !== 10'd0) begin n_err++; $display("FAIL halt_reset halted/pc got %b/%0d exp 0/0", halted, pc); end
      rst_n = 1;
      idle();
   endtask

   task automatic test_wrap();
      goto_pc(10'd1023);
      n_vec++; if (pc_plus1 !== 10'd0) begin n_err++; $display("FAIL pc_plus1_wrap got %0d exp 0", pc_plus1); end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (pc !== 10'd0) begin n_err++; $display("FAIL pc_wrap got %0d exp 0", pc); end
      while (exp_cnt != 16'd15) begin
         tick();
         exp_cnt = exp_cnt + 16'd1;
      end
      n_vec++; if (instr_count_s !== 4'hF || instr_count !== 16'd15) begin n_err++; $display("FAIL cnt_pre_wrap got %h/%0d exp f/15", instr_count_s, instr_count); end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++; if (instr_count_s !== 4'h0 || instr_count !== 16'd16) begin n_err++; $display("FAIL cnt_wrap got %h/%0d exp 0/16", instr_count_s, instr_count); end
   endtask

   initial begin
      rst_n = 0;
      idle();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_wait_in();
      test_halt();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
